// File: rtl/pipe_field_if.sv
// Game-field bus between the pipe/score controller and its neighbours:
// tick/start/bird_y come in from the game logic and bird physics, and the
// pipe position, gap, score and game state go out to the renderer and HUD.
interface pipe_field_if;
    logic       tick;
    logic       start;
    logic [8:0] bird_y;
    logic [9:0] pipe_x;
    logic [8:0] gap_y;
    logic [7:0] score;
    logic [1:0] state;
    logic       alive;
    logic       collision;

    modport master (
        output tick, start, bird_y,
        input  pipe_x, gap_y, score, state, alive, collision
    );

    modport slave (
        input  tick, start, bird_y,
        output pipe_x, gap_y, score, state, alive, collision
    );
endinterface

// File: rtl/pipe_field_ctrl.sv
// Pipe field controller: scrolls one pipe, randomises its gap, detects
// bird/pipe and bird/ground collisions, keeps score and runs IDLE/RUN/DEAD.
module pipe_field_ctrl #(
    parameter int unsigned BIRD_X   = 160,
    parameter int unsigned BIRD_R   = 8,
    parameter int unsigned PIPE_W   = 52,
    parameter int unsigned GAP_HALF = 40,
    parameter int unsigned GAP_MIN  = 48,
    parameter int unsigned SPAWN_X  = 640,
    parameter int unsigned SCROLL   = 2
) (
    input logic         clk,
    input logic         rst_n,
    pipe_field_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    localparam logic [9:0] SPAWN_PX   = 10'(SPAWN_X);
    localparam logic [8:0] RESET_GAP  = 9'd128;
    localparam logic [7:0] LFSR_SEED  = 8'hA5;

    // Collision bounds in 11-bit signed so that sums of 10-bit positions and
    // negative bird heights can never wrap.
    localparam logic signed [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_R);
    localparam logic signed [10:0] BIRD_LEFT  = 11'(BIRD_X - BIRD_R);
    localparam logic signed [10:0] PIPE_W_S   = 11'(PIPE_W);
    localparam logic signed [10:0] BIRD_R_S   = 11'(BIRD_R);
    localparam logic signed [10:0] GAP_HALF_S = 11'(GAP_HALF);

    state_t      state_q, state_d;
    logic [9:0]  pipe_x_q, pipe_x_d;
    logic [8:0]  gap_y_q, gap_y_d;
    logic [7:0]  score_q, score_d;
    logic        scored_q, scored_d;
    logic        collision_q, collision_d;
    logic        alive_q, alive_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic signed [10:0] px_s, by_s, gy_s, new_px_s;
    logic               ground_hit, pipe_hit_x, pipe_hit_y, hit;
    logic [9:0]         scrolled_px;

    // Signed views of the current pipe, gap and bird for the collision test.
    always_comb begin
        px_s        = signed'({1'b0, pipe_x_q});
        by_s        = 11'(signed'(bus.bird_y));
        gy_s        = signed'({2'b00, gap_y_q});
        scrolled_px = pipe_x_q - 10'(SCROLL);
        new_px_s    = signed'({1'b0, scrolled_px});
        ground_hit  = (by_s <= 11'sd0);
        pipe_hit_x  = (px_s <= BIRD_RIGHT) && ((px_s + PIPE_W_S) > BIRD_LEFT);
        pipe_hit_y  = ((by_s - BIRD_R_S) < (gy_s - GAP_HALF_S)) ||
                      ((by_s + BIRD_R_S) > (gy_s + GAP_HALF_S));
        hit         = ground_hit || (pipe_hit_x && pipe_hit_y);
    end

    // Next-state logic for the game FSM, pipe, score and LFSR.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        pipe_x_d    = pipe_x_q;
        gap_y_d     = gap_y_q;
        score_d     = score_q;
        scored_d    = scored_q;
        collision_d = 1'b0;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        unique case (state_q)
            IDLE, DEAD: begin
                // start wins over a same-cycle tick; the tick is dropped.
                if (bus.start) begin
                    state_d  = RUN;
                    pipe_x_d = SPAWN_PX;
                    gap_y_d  = RESET_GAP;
                    score_d  = '0;
                    scored_d = 1'b0;
                end
            end
            RUN: begin
                if (bus.tick) begin
                    if (hit) begin
                        state_d     = DEAD;
                        collision_d = 1'b1;
                    end else if (pipe_x_q < 10'(SCROLL)) begin
                        pipe_x_d = SPAWN_PX;
                        gap_y_d  = 9'(GAP_MIN) + {2'b00, lfsr_q[6:0]};
                        scored_d = 1'b0;
                    end else begin
                        pipe_x_d = scrolled_px;
                        if (((new_px_s + PIPE_W_S) <= BIRD_LEFT) && !scored_q) begin
                            scored_d = 1'b1;
                            if (score_q != 8'hFF) begin
                                score_d = score_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        alive_d = (state_d == RUN);
    end

    // State register; reset restores the idle field and clears any pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pipe_x_q    <= SPAWN_PX;
            gap_y_q     <= RESET_GAP;
            score_q     <= '0;
            scored_q    <= 1'b0;
            collision_q <= 1'b0;
            alive_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            pipe_x_q    <= pipe_x_d;
            gap_y_q     <= gap_y_d;
            score_q     <= score_d;
            scored_q    <= scored_d;
            collision_q <= collision_d;
            alive_q     <= alive_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign bus.pipe_x    = pipe_x_q;
    assign bus.gap_y     = gap_y_q;
    assign bus.score     = score_q;
    assign bus.state     = state_q;
    assign bus.alive     = alive_q;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_pipe_field_ctrl.sv
// Directed bench for pipe_field_ctrl: a vector table for the basic FSM
// behaviour plus hand-written sequences for scoring, respawn, collisions,
// restart priority and asynchronous reset.
module tb_pipe_field_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    pipe_field_if bus ();

    pipe_field_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int px, input int gy,
                             input int sc, input int col);
        check({tag, " state"}, int'(bus.state), st);
        check({tag, " alive"}, int'(bus.alive), (st == 1) ? 1 : 0);
        check({tag, " pipe_x"}, int'(bus.pipe_x), px);
        check({tag, " gap_y"}, int'(bus.gap_y), gy);
        check({tag, " score"}, int'(bus.score), sc);
        check({tag, " collision"}, int'(bus.collision), col);
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic s, input logic t, input logic [8:0] by);
        bus.start  = s;
        bus.tick   = t;
        bus.bird_y = by;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.tick  = 1'b0;
    endtask

    task automatic run_ticks(input int n, input logic [8:0] by);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, by);
    endtask

    typedef struct {
        logic       start;
        logic       tick;
        logic [8:0] bird_y;
        int         st;
        int         px;
        int         sc;
        int         col;
    } vec_t;

    vec_t vecs[12];
    int   exp_gap;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 9'd128, 0, 640, 0, 0}; // tick ignored in IDLE
        vecs[1]  = '{1'b1, 1'b0, 9'd128, 1, 640, 0, 0}; // start -> RUN
        vecs[2]  = '{1'b0, 1'b1, 9'd128, 1, 638, 0, 0}; // scroll
        vecs[3]  = '{1'b0, 1'b0, 9'd128, 1, 638, 0, 0}; // no tick: hold
        vecs[4]  = '{1'b1, 1'b0, 9'd128, 1, 638, 0, 0}; // start in RUN ignored
        vecs[5]  = '{1'b0, 1'b1, 9'd1,   1, 636, 0, 0}; // y=1 above ground
        vecs[6]  = '{1'b0, 1'b1, 9'd0,   2, 636, 0, 1}; // ground hit, frozen
        vecs[7]  = '{1'b0, 1'b0, 9'd128, 2, 636, 0, 0}; // pulse is one cycle
        vecs[8]  = '{1'b0, 1'b1, 9'd128, 2, 636, 0, 0}; // tick ignored in DEAD
        vecs[9]  = '{1'b1, 1'b1, 9'd128, 1, 640, 0, 0}; // start beats tick
        vecs[10] = '{1'b0, 1'b1, 9'h1F0, 2, 640, 0, 1}; // y=-16 ground hit
        vecs[11] = '{1'b1, 1'b0, 9'd128, 1, 640, 0, 0}; // restart

        bus.start  = 1'b0;
        bus.tick   = 1'b0;
        bus.bird_y = 9'd128;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_all("reset", 0, 640, 128, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].start, vecs[i].tick, vecs[i].bird_y);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].px, 128,
                      vecs[i].sc, vecs[i].col);
        end

        // Clean pass at y=128 from a fresh RUN at 640.
        run_ticks(269, 9'd128);
        check_all("pass tick269", 1, 102, 128, 0, 0);
        step(1'b0, 1'b1, 9'd128);
        check_all("pass tick270", 1, 100, 128, 1, 0);
        run_ticks(50, 9'd128);
        check_all("pass tick320", 1, 0, 128, 1, 0);

        // Respawn: gap comes from the LFSR value present in the tick cycle.
        exp_gap = 48 + int'(m_lfsr[6:0]);
        step(1'b0, 1'b1, 9'd128);
        check_all("respawn", 1, 640, exp_gap, 1, 0);
        check("respawn gap_lo", (bus.gap_y >= 9'd48) ? 1 : 0, 1);
        check("respawn gap_hi", (bus.gap_y <= 9'd175) ? 1 : 0, 1);

        // Second pass through the new gap; scored flag must have cleared.
        run_ticks(269, 9'(exp_gap));
        check_all("pass2 tick269", 1, 102, exp_gap, 1, 0);
        step(1'b0, 1'b1, 9'(exp_gap));
        check_all("pass2 tick270", 1, 100, exp_gap, 2, 0);

        // Ground hits: y=1 survives clear of the pipe, y=0 and y=-16 die.
        step(1'b0, 1'b1, 9'd1);
        check_all("ground y1", 1, 98, exp_gap, 2, 0);
        step(1'b0, 1'b1, 9'd0);
        check_all("ground y0", 2, 98, exp_gap, 2, 1);
        step(1'b0, 1'b0, 9'd128);
        check_all("ground y0 after", 2, 98, exp_gap, 2, 0);
        step(1'b1, 1'b0, 9'd128);
        check_all("restart1", 1, 640, 128, 0, 0);
        step(1'b0, 1'b1, 9'h1F0);
        check_all("ground neg16", 2, 640, 128, 0, 1);
        step(1'b0, 1'b0, 9'd128);
        check_all("ground neg16 after", 2, 640, 128, 0, 0);

        // start and tick together in DEAD: RUN, no pipe movement.
        step(1'b1, 1'b1, 9'd128);
        check_all("restart prio", 1, 640, 128, 0, 0);
        step(1'b0, 1'b0, 9'd128);
        check_all("restart hold", 1, 640, 128, 0, 0);

        // Pipe hit with bird above the gap.
        run_ticks(236, 9'd200);
        check_all("hit tick236", 1, 168, 128, 0, 0);
        step(1'b0, 1'b1, 9'd200);
        check_all("hit tick237", 2, 168, 128, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 9'd200);
            check_all($sformatf("dead tick%0d", i), 2, 168, 128, 0, 0);
        end

        // Reset mid-RUN at pipe_x=300.
        step(1'b1, 1'b0, 9'd128);
        run_ticks(170, 9'd128);
        check_all("pre-reset", 1, 300, 128, 0, 0);
        rst_n = 1'b0;
        #1 check_all("mid reset", 0, 640, 128, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset clears a collision pulse in flight.
        step(1'b1, 1'b0, 9'd128);
        step(1'b0, 1'b1, 9'd0);
        check_all("pulse before reset", 2, 640, 128, 0, 1);
        rst_n = 1'b0;
        #1 check_all("pulse reset", 0, 640, 128, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
